// File: rtl/wb_mem_pkg.sv
// Shared types and widths for the Wishbone responder memory.
package wb_mem_pkg;

  localparam int unsigned WB_DATA_W  = 32;
  localparam int unsigned WB_SEL_W   = 4;
  localparam int unsigned WB_ADDR_W  = 32;
  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned GAP_CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    GAP
  } wb_state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wb_mem_responder_if.sv
// Single-word Wishbone bus between an initiator and the responder memory.
interface wb_mem_responder_if;
  import wb_mem_pkg::*;

  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [WB_SEL_W-1:0]  sel_i;
  logic [WB_ADDR_W-1:0] addr_i;
  logic [WB_DATA_W-1:0] data_i;
  logic [WB_DATA_W-1:0] data_o;
  logic                 ack_o;
  logic                 err_o;

  modport master (
    output cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    input  data_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    output data_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_mem_bram.sv
// Byte-enable synchronous RAM with one registered read port.
module wb_mem_bram
  import wb_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned IDX_W     = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WB_SEL_W-1:0]  we_i,
  input  logic                 re_i,
  input  logic                 clr_i,
  input  logic [IDX_W-1:0]     addr_i,
  input  logic [WB_DATA_W-1:0] wdata_i,
  output logic [WB_DATA_W-1:0] rdata_o
);

  logic [WB_DATA_W-1:0] mem_q [MEM_WORDS];
  logic [WB_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WB_SEL_W; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  // Output register doubles as the bus read-data holder, so it is only
  // loaded on a read response and otherwise keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone responder memory: IDLE->WAIT->RESP->GAP handshake around a byte-lane RAM.
// Define WB_ERR_EN to answer out-of-range accesses with err_o instead of ack_o.
module wb_mem_responder
  import wb_mem_pkg::*;
#(
  parameter int unsigned          MEM_WORDS   = 4096,
  parameter logic [WB_ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned          WAIT_STATES = 1,
  parameter int unsigned          ACK_GAP     = 1,
  parameter string                INIT_FILE   = ""
) (
  input logic               clk,
  input logic               rst,
  wb_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(MEM_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LAST  = GAP_CNT_W'(ACK_GAP - 1);

  wb_state_e            state_q;
  logic                 we_q;
  logic [WB_SEL_W-1:0]  sel_q;
  logic [WB_ADDR_W-1:0] addr_q;
  logic [WB_DATA_W-1:0] data_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [GAP_CNT_W-1:0]  gap_cnt_q;
  logic                 ack_q;
  logic                 err_q;

  logic                 cur_we;
  logic [WB_SEL_W-1:0]  cur_sel;
  logic [WB_ADDR_W-1:0] cur_addr;
  logic [WB_DATA_W-1:0] cur_data;
  logic                 borrow;
  logic [WB_ADDR_W-1:0] off;
  logic [WB_ADDR_W-1:0] word_off;
  logic                 in_range;
  logic                 accept;
  logic                 fire;
  logic                 ack_d;
  logic                 err_d;
  logic [WB_SEL_W-1:0]  ram_we;
  logic                 ram_re;
  logic                 ram_clr;
  logic [WB_DATA_W-1:0] ram_rdata;

  // With zero wait states the response edge is the accept edge itself, so the
  // request is taken straight from the bus while IDLE and from the latch after.
  always_comb begin
    cur_we   = we_q;
    cur_sel  = sel_q;
    cur_addr = addr_q;
    cur_data = data_q;
    if (state_q == IDLE) begin
      cur_we   = bus.we_i;
      cur_sel  = bus.sel_i;
      cur_addr = bus.addr_i;
      cur_data = bus.data_i;
    end

    {borrow, off} = {1'b0, cur_addr} - {1'b0, ADDR_BASE};
    word_off = off >> 2;
    in_range = !borrow && (word_off < MEM_WORDS);

    accept = (state_q == IDLE) && bus.cyc_i && bus.stb_i;
    fire   = 1'b0;
    if (!rst) begin
      if (accept && (WAIT_STATES == 0)) fire = 1'b1;
      if ((state_q == WAIT) && bus.cyc_i && (wait_cnt_q == WAIT_LAST)) fire = 1'b1;
    end

`ifdef WB_ERR_EN
    ack_d   = fire && in_range;
    err_d   = fire && !in_range;
    ram_clr = 1'b0;
`else
    ack_d   = fire;
    err_d   = 1'b0;
    ram_clr = fire && !cur_we && !in_range;
`endif

    ram_we = (fire && cur_we && in_range) ? cur_sel : '0;
    ram_re = fire && !cur_we && in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q       <= bus.we_i;
            sel_q      <= bus.sel_i;
            addr_q     <= bus.addr_i;
            data_q     <= bus.data_i;
            wait_cnt_q <= '0;
            state_q    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!bus.cyc_i) begin
            state_q <= IDLE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        RESP: begin
          gap_cnt_q <= '0;
          state_q   <= (ACK_GAP == 0) ? IDLE : GAP;
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  wb_mem_bram #(
    .MEM_WORDS(MEM_WORDS),
    .IDX_W    (IDX_W),
    .INIT_FILE(INIT_FILE)
  ) u_bram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .clr_i  (ram_clr),
    .addr_i (word_off[IDX_W-1:0]),
    .wdata_i(cur_data),
    .rdata_o(ram_rdata)
  );

  assign bus.data_o = ram_rdata;
  assign bus.ack_o  = ack_q;
  assign bus.err_o  = err_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder (WAIT_STATES=1, ACK_GAP=1, 1024 words at base 0).
module tb_wb_mem_responder;
  import wb_mem_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_mem_responder_if bus ();

  wb_mem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .ADDR_BASE  (32'h0000_0000),
    .WAIT_STATES(1),
    .ACK_GAP    (1),
    .INIT_FILE  ("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          t_lat;
  logic        t_ack;
  logic        t_err;
  logic        t_ack_next;
  logic [31:0] t_rdata;
  int          acks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.cyc_i  = 1'b0;
    bus.stb_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.sel_i  = '0;
    bus.addr_i = '0;
    bus.data_i = '0;
  endtask

  task automatic drive(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    bus.we_i   = we;
    bus.sel_i  = sel;
    bus.addr_i = addr;
    bus.data_i = wdata;
  endtask

  // One transfer: latency counted in edges from request to first ack/err sample.
  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata);
    drive(we, sel, addr, wdata);
    t_lat = 0; t_ack = 1'b0; t_err = 1'b0; t_ack_next = 1'b0; t_rdata = '0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o || bus.err_o) begin
        t_lat = i; t_ack = bus.ack_o; t_err = bus.err_o; t_rdata = bus.data_o;
        break;
      end
    end
    idle_bus();
    @(posedge clk); #1;
    t_ack_next = bus.ack_o | bus.err_o;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'h0);
    check("rst_err", 32'(bus.err_o), 32'h0);
    check("rst_data", bus.data_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: full write then read, ack two edges after request
    wb_xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    check("t1_wr_lat", 32'(t_lat), 32'd2);
    check("t1_wr_ack", 32'(t_ack), 32'h1);
    check("t1_wr_err", 32'(t_err), 32'h0);
    check("t1_wr_pulse", 32'(t_ack_next), 32'h0);
    check("t1_wr_no_data", bus.data_o, 32'h0);
    wb_xfer(1'b0, 4'h0, 32'h10, 32'h0);
    check("t1_rd_lat", 32'(t_lat), 32'd2);
    check("t1_rd_data", t_rdata, 32'hDEADBEEF);
    check("t1_rd_pulse", 32'(t_ack_next), 32'h0);

    // 2: single-lane write, then a sel=0 write that must not change memory
    wb_xfer(1'b1, 4'b0010, 32'h10, 32'h0000AB00);
    wb_xfer(1'b0, 4'h0, 32'h10, 32'h0);
    check("t2_lane_data", t_rdata, 32'hDEADABEF);
    wb_xfer(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF);
    check("t2_sel0_ack", 32'(t_ack), 32'h1);
    wb_xfer(1'b0, 4'hF, 32'h10, 32'h0);
    check("t2_sel0_data", t_rdata, 32'hDEADABEF);

    // 3: cyc dropped in WAIT aborts; stb dropped with cyc held still completes
    wb_xfer(1'b1, 4'hF, 32'h20, 32'h0);
    drive(1'b1, 4'hF, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    idle_bus();
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      acks += int'(bus.ack_o | bus.err_o);
    end
    check("t3_abort_noack", 32'(acks), 32'h0);
    wb_xfer(1'b0, 4'h0, 32'h20, 32'h0);
    check("t3_abort_lat", 32'(t_lat), 32'd2);
    check("t3_abort_data", t_rdata, 32'h0);
    drive(1'b1, 4'hF, 32'h24, 32'hA5A5A5A5);
    @(posedge clk); #1;
    bus.stb_i = 1'b0;
    @(posedge clk); #1;
    check("t3_stbdrop_ack", 32'(bus.ack_o), 32'h1);
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    wb_xfer(1'b0, 4'h0, 32'h24, 32'h0);
    check("t3_stbdrop_data", t_rdata, 32'hA5A5A5A5);

    // 4: last word in range, one past the end out of range
    wb_xfer(1'b1, 4'hF, 32'h0, 32'h01020304);
    wb_xfer(1'b1, 4'hF, 32'hFFC, 32'hFEEDC0DE);
    wb_xfer(1'b0, 4'h0, 32'hFFC, 32'h0);
    check("t4_last_data", t_rdata, 32'hFEEDC0DE);
    wb_xfer(1'b0, 4'h0, 32'h1000, 32'h0);
`ifdef WB_ERR_EN
    check("t4_oor_rd_ack", 32'(t_ack), 32'h0);
    check("t4_oor_rd_err", 32'(t_err), 32'h1);
    check("t4_oor_rd_data", t_rdata, 32'hFEEDC0DE);
`else
    check("t4_oor_rd_ack", 32'(t_ack), 32'h1);
    check("t4_oor_rd_err", 32'(t_err), 32'h0);
    check("t4_oor_rd_data", t_rdata, 32'h0);
`endif
    wb_xfer(1'b1, 4'hF, 32'h1000, 32'h55555555);
`ifdef WB_ERR_EN
    check("t4_oor_wr_err", 32'(t_err), 32'h1);
`else
    check("t4_oor_wr_ack", 32'(t_ack), 32'h1);
`endif
    wb_xfer(1'b0, 4'h0, 32'h0, 32'h0);
    check("t4_word0_data", t_rdata, 32'h01020304);

    // 5: stb held through the ack cycle and one more -> single ack
    drive(1'b0, 4'h0, 32'h10, 32'h0);
    acks = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      acks += int'(bus.ack_o);
      if (k == 4) idle_bus();
    end
    check("t5_gap_acks", 32'(acks), 32'h1);
    wb_xfer(1'b0, 4'h0, 32'h10, 32'h0);
    check("t5_second_lat", 32'(t_lat), 32'd2);
    check("t5_second_data", t_rdata, 32'hDEADABEF);

    // 6: reset during WAIT discards the pending write
    wb_xfer(1'b1, 4'hF, 32'h30, 32'h11223344);
    drive(1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_ack", 32'(bus.ack_o), 32'h0);
    check("t6_rst_data", bus.data_o, 32'h0);
    rst = 1'b0;
    idle_bus();
    @(posedge clk); #1;
    wb_xfer(1'b0, 4'h0, 32'h30, 32'h0);
    check("t6_prior_data", t_rdata, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
